// File: rtl/arrow_lane_renderer.sv
// arrow_lane_renderer: per-lane scrolling note queues with hit/miss judging,
// a saturating score, and a one-cycle registered pixel renderer that draws
// notes over the target-row frames over a white background.
module arrow_lane_renderer #(
  parameter int LANES      = 4,
  parameter int NOTES      = 4,
  parameter int ARROW_SIZE = 72,
  parameter int LANE_X0    = 146,
  parameter int LANE_PITCH = 92,
  parameter int TARGET_Y   = 36,
  parameter int SPAWN_Y    = 480,
  parameter int SPEED      = 4,
  parameter int WINDOW     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      pix_x,
  input  logic [10:0]      pix_y,
  input  logic             frame_start,
  input  logic             spawn_valid,
  input  logic [2:0]       spawn_lane,
  output logic             spawn_ready,
  input  logic [LANES-1:0] hit,
  output logic [LANES-1:0] hit_ok,
  output logic [LANES-1:0] miss,
  output logic [15:0]      score,
  output logic [9:0]       pix_r,
  output logic [9:0]       pix_g,
  output logic [9:0]       pix_b
);

  localparam int PW = $clog2(NOTES);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL    = CW'(NOTES);
  localparam logic [10:0]   Y_SPAWN = 11'(SPAWN_Y);
  localparam logic [10:0]   Y_SPEED = 11'(SPEED);
  localparam logic [10:0]   Y_LO    = 11'(TARGET_Y - WINDOW);
  localparam logic [10:0]   Y_HI    = 11'(TARGET_Y + WINDOW);
  localparam logic [29:0]   WHITE   = {10'h3FF, 10'h3FF, 10'h3FF};
  localparam logic [29:0]   GRAY    = {10'h2A8, 10'h2A8, 10'h2A8};

  // Lane colour cycles red, blue, green, yellow
  function automatic logic [29:0] lane_colour(input int l);
    case (l % 4)
      0:       lane_colour = {10'h3FF, 10'h000, 10'h000};
      1:       lane_colour = {10'h000, 10'h000, 10'h3FF};
      2:       lane_colour = {10'h000, 10'h3FF, 10'h000};
      default: lane_colour = {10'h3FF, 10'h3FF, 10'h000};
    endcase
  endfunction

  logic [10:0]      note_y   [LANES][NOTES];
  logic [10:0]      note_y_d [LANES][NOTES];
  logic [PW-1:0]    head_q   [LANES];
  logic [PW-1:0]    head_d   [LANES];
  logic [PW-1:0]    tail_q   [LANES];
  logic [PW-1:0]    tail_d   [LANES];
  logic [CW-1:0]    count_q  [LANES];
  logic [CW-1:0]    count_d  [LANES];
  logic [NOTES-1:0] occupied [LANES];
  logic [LANES-1:0] hit_pop;
  logic [LANES-1:0] miss_pop;
  logic [3:0]       hit_total;
  logic [16:0]      score_sum;
  logic [15:0]      score_d;
  logic [29:0]      colour;

  // An entry is live when its distance from head (mod ring size) is below count
  always_comb begin
    logic [PW-1:0] offset;
    offset = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int n = 0; n < NOTES; n++) begin
        offset = PW'(n) - head_q[l];
        occupied[l][n] = ({1'b0, offset} < count_q[l]);
      end
    end
  end

  // Spawn is allowed only for an in-range lane that is not already full
  always_comb begin
    spawn_ready = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (int'(spawn_lane) == l) spawn_ready = (count_q[l] != FULL);
    end
  end

  // Per lane: judge hit on pre-scroll head, then miss on the post-scroll head, scroll, spawn
  always_comb begin
    logic [PW-1:0] hd;
    logic [CW-1:0] cnt;
    logic [10:0]   head_y;
    hd       = '0;
    cnt      = '0;
    head_y   = '0;
    hit_pop  = '0;
    miss_pop = '0;
    for (int l = 0; l < LANES; l++) begin
      hd     = head_q[l];
      cnt    = count_q[l];
      head_y = note_y[l][head_q[l]];
      hit_pop[l] = hit[l] && (cnt != '0) && (head_y >= Y_LO) && (head_y <= Y_HI);
      if (hit_pop[l]) begin
        hd  = hd + 1'b1;
        cnt = cnt - 1'b1;
      end
      miss_pop[l] = frame_start && (cnt != '0) && ((note_y[l][hd] - Y_SPEED) < Y_LO);
      if (miss_pop[l]) begin
        hd  = hd + 1'b1;
        cnt = cnt - 1'b1;
      end
      for (int n = 0; n < NOTES; n++) begin
        note_y_d[l][n] = note_y[l][n];
        if (frame_start && occupied[l][n]) note_y_d[l][n] = note_y[l][n] - Y_SPEED;
      end
      tail_d[l] = tail_q[l];
      if (spawn_valid && (int'(spawn_lane) == l) && (count_q[l] != FULL)) begin
        note_y_d[l][tail_q[l]] = Y_SPAWN;
        tail_d[l] = tail_q[l] + 1'b1;
        cnt = cnt + 1'b1;
      end
      head_d[l]  = hd;
      count_d[l] = cnt;
    end
  end

  // Several lanes can be hit in one cycle; the score saturates at all ones
  always_comb begin
    hit_total = '0;
    for (int l = 0; l < LANES; l++) hit_total = hit_total + 4'(hit_pop[l]);
    score_sum = {1'b0, score} + 17'(hit_total);
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  // Queue state, score and judgement pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++) begin
        head_q[l]  <= '0;
        tail_q[l]  <= '0;
        count_q[l] <= '0;
        for (int n = 0; n < NOTES; n++) note_y[l][n] <= '0;
      end
      hit_ok <= '0;
      miss   <= '0;
      score  <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        head_q[l]  <= head_d[l];
        tail_q[l]  <= tail_d[l];
        count_q[l] <= count_d[l];
        for (int n = 0; n < NOTES; n++) note_y[l][n] <= note_y_d[l][n];
      end
      hit_ok <= hit_pop;
      miss   <= miss_pop;
      score  <= score_d;
    end
  end

  // Pick the pixel colour: any live note, else a target frame outline, else background
  always_comb begin
    int          px;
    int          py;
    int          x0;
    logic        note_any;
    logic        frame_any;
    logic [29:0] note_col;
    px        = int'(pix_x);
    py        = int'(pix_y);
    x0        = 0;
    note_any  = 1'b0;
    frame_any = 1'b0;
    note_col  = WHITE;
    for (int l = LANES - 1; l >= 0; l--) begin
      x0 = LANE_X0 + l * LANE_PITCH;
      if (px >= x0 && px < x0 + ARROW_SIZE) begin
        for (int n = 0; n < NOTES; n++) begin
          if (occupied[l][n] && py >= int'(note_y[l][n]) &&
              py < int'(note_y[l][n]) + ARROW_SIZE) begin
            note_any = 1'b1;
            note_col = lane_colour(l);
          end
        end
        if (py >= TARGET_Y && py < TARGET_Y + ARROW_SIZE &&
            !(px >= x0 + 4 && px < x0 + ARROW_SIZE - 4 &&
              py >= TARGET_Y + 4 && py < TARGET_Y + ARROW_SIZE - 4))
          frame_any = 1'b1;
      end
    end
    if (note_any)       colour = note_col;
    else if (frame_any) colour = GRAY;
    else                colour = WHITE;
  end

  // One-cycle registered pixel output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {pix_r, pix_g, pix_b} <= '0;
    else     {pix_r, pix_g, pix_b} <= colour;
  end

endmodule

// File: tb/tb_arrow_lane_renderer.sv
// tb_arrow_lane_renderer: directed scenarios followed by random traffic, all
// compared against a list-based model of the note highway.
module tb_arrow_lane_renderer;

  localparam int LANES      = 4;
  localparam int NOTES      = 4;
  localparam int ARROW_SIZE = 72;
  localparam int LANE_X0    = 146;
  localparam int LANE_PITCH = 92;
  localparam int TARGET_Y   = 36;
  localparam int SPAWN_Y    = 480;
  localparam int SPEED      = 4;
  localparam int WINDOW     = 12;

  localparam logic [29:0] WHITE = {10'h3FF, 10'h3FF, 10'h3FF};
  localparam logic [29:0] GRAY  = {10'h2A8, 10'h2A8, 10'h2A8};
  localparam logic [29:0] RED   = {10'h3FF, 10'h000, 10'h000};
  localparam logic [29:0] GREEN = {10'h000, 10'h3FF, 10'h000};

  logic             clk = 1'b0;
  logic             rst;
  logic [10:0]      pix_x;
  logic [10:0]      pix_y;
  logic             frame_start;
  logic             spawn_valid;
  logic [2:0]       spawn_lane;
  logic             spawn_ready;
  logic [LANES-1:0] hit;
  logic [LANES-1:0] hit_ok;
  logic [LANES-1:0] miss;
  logic [15:0]      score;
  logic [9:0]       pix_r;
  logic [9:0]       pix_g;
  logic [9:0]       pix_b;

  int pass_count  = 0;
  int fail_count  = 0;
  int check_count = 0;

  // Model: per lane an oldest-first list of note y values, plus the score
  int model_y   [LANES][NOTES];
  int model_cnt [LANES];
  int model_score;
  logic [LANES-1:0] exp_hit;
  logic [LANES-1:0] exp_miss;

  arrow_lane_renderer dut (
    .clk         (clk),
    .rst         (rst),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_start (frame_start),
    .spawn_valid (spawn_valid),
    .spawn_lane  (spawn_lane),
    .spawn_ready (spawn_ready),
    .hit         (hit),
    .hit_ok      (hit_ok),
    .miss        (miss),
    .score       (score),
    .pix_r       (pix_r),
    .pix_g       (pix_g),
    .pix_b       (pix_b)
  );

  // Free-running pixel clock
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic bit model_ready(input int sl);
    if (sl >= LANES) return 1'b0;
    return model_cnt[sl] < NOTES;
  endfunction

  task automatic model_pop(input int l);
    for (int i = 0; i < NOTES - 1; i++) model_y[l][i] = model_y[l][i + 1];
    model_cnt[l]--;
  endtask

  task automatic model_clear();
    for (int l = 0; l < LANES; l++) model_cnt[l] = 0;
    model_score = 0;
  endtask

  task automatic model_step(input bit fs, input bit sv, input int sl,
                            input logic [LANES-1:0] h);
    bit take;
    int d;
    take = sv && model_ready(sl);
    exp_hit  = '0;
    exp_miss = '0;
    for (int l = 0; l < LANES; l++) begin
      if (h[l] && model_cnt[l] > 0) begin
        d = model_y[l][0] - TARGET_Y;
        if (d < 0) d = -d;
        if (d <= WINDOW) begin
          model_pop(l);
          exp_hit[l] = 1'b1;
          if (model_score < 65535) model_score++;
        end
      end
      if (fs) begin
        for (int i = 0; i < model_cnt[l]; i++) model_y[l][i] -= SPEED;
        if (model_cnt[l] > 0 && model_y[l][0] < TARGET_Y - WINDOW) begin
          model_pop(l);
          exp_miss[l] = 1'b1;
        end
      end
    end
    if (take) begin
      model_y[sl][model_cnt[sl]] = SPAWN_Y;
      model_cnt[sl]++;
    end
  endtask

  function automatic logic [29:0] model_pixel(input int x, input int y);
    int xl;
    for (int l = 0; l < LANES; l++) begin
      xl = LANE_X0 + l * LANE_PITCH;
      if (x >= xl && x < xl + ARROW_SIZE)
        for (int i = 0; i < model_cnt[l]; i++)
          if (y >= model_y[l][i] && y < model_y[l][i] + ARROW_SIZE)
            case (l % 4)
              0: return RED;
              1: return {10'h000, 10'h000, 10'h3FF};
              2: return GREEN;
              default: return {10'h3FF, 10'h3FF, 10'h000};
            endcase
    end
    for (int l = 0; l < LANES; l++) begin
      xl = LANE_X0 + l * LANE_PITCH;
      if (x >= xl && x < xl + ARROW_SIZE && y >= TARGET_Y && y < TARGET_Y + ARROW_SIZE) begin
        if (!(x >= xl + 4 && x < xl + ARROW_SIZE - 4 &&
              y >= TARGET_Y + 4 && y < TARGET_Y + ARROW_SIZE - 4))
          return GRAY;
      end
    end
    return WHITE;
  endfunction

  // One clock of stimulus with every output compared to the model
  task automatic apply_stimulus(input bit fs, input bit sv, input logic [2:0] sl,
                                input logic [LANES-1:0] h,
                                input logic [10:0] px, input logic [10:0] py);
    logic [29:0] exp_pix;
    frame_start = fs;
    spawn_valid = sv;
    spawn_lane  = sl;
    hit         = h;
    pix_x       = px;
    pix_y       = py;
    #1;
    check_output("spawn_ready", 32'(spawn_ready), 32'(model_ready(int'(sl))));
    exp_pix = model_pixel(int'(px), int'(py));
    model_step(fs, sv, int'(sl), h);
    @(posedge clk);
    #1;
    check_output("hit_ok", 32'(hit_ok), 32'(exp_hit));
    check_output("miss", 32'(miss), 32'(exp_miss));
    check_output("score", 32'(score), 32'(model_score));
    check_output("pixel", 32'({pix_r, pix_g, pix_b}), 32'(exp_pix));
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++)
      apply_stimulus(1'b1, 1'b0, 3'd0, '0, 11'($urandom_range(100, 520)),
                     11'($urandom_range(0, 560)));
  endtask

  task automatic probe_ready(input logic [2:0] sl, input bit expected);
    spawn_valid = 1'b0;
    spawn_lane  = sl;
    #1;
    check_output("spawn_ready_probe", 32'(spawn_ready), 32'(expected));
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    rst         = 1'b1;
    frame_start = 1'b0;
    spawn_valid = 1'b0;
    spawn_lane  = 3'd0;
    hit         = '0;
    model_clear();
    #1;
    check_output("rst_hit_ok", 32'(hit_ok), 32'd0);
    check_output("rst_miss", 32'(miss), 32'd0);
    check_output("rst_score", 32'(score), 32'd0);
    check_output("rst_pixel", 32'({pix_r, pix_g, pix_b}), 32'd0);
    check_output("rst_ready", 32'(spawn_ready), 32'd1);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    logic [LANES-1:0] rand_hit;
    pix_x = '0;
    pix_y = '0;
    do_reset();

    $display("[TB] idle pixels");
    apply_stimulus(1'b0, 1'b0, 3'd0, '0, 11'd0, 11'd0);
    check_output("pix_origin", 32'({pix_r, pix_g, pix_b}), 32'(WHITE));
    apply_stimulus(1'b0, 1'b0, 3'd0, '0, 11'd146, 11'd36);
    check_output("pix_frame", 32'({pix_r, pix_g, pix_b}), 32'(GRAY));
    apply_stimulus(1'b0, 1'b0, 3'd0, '0, 11'd186, 11'd76);
    check_output("pix_frame_inside", 32'({pix_r, pix_g, pix_b}), 32'(WHITE));

    $display("[TB] note render on lane 2");
    do_reset();
    apply_stimulus(1'b0, 1'b1, 3'd2, '0, 11'd0, 11'd0);
    run_frames(4);
    apply_stimulus(1'b0, 1'b0, 3'd0, '0, 11'd330, 11'd470);
    check_output("pix_note_green", 32'({pix_r, pix_g, pix_b}), 32'(GREEN));
    apply_stimulus(1'b0, 1'b0, 3'd0, '0, 11'd330, 11'd463);
    check_output("pix_above_note", 32'({pix_r, pix_g, pix_b}), 32'(WHITE));

    $display("[TB] hit inside window");
    do_reset();
    apply_stimulus(1'b0, 1'b1, 3'd0, '0, 11'd0, 11'd0);
    run_frames(108);
    apply_stimulus(1'b0, 1'b0, 3'd0, 4'b0001, 11'd180, 11'd60);
    check_output("hit_pulse", 32'(hit_ok), 32'd1);
    check_output("hit_score", 32'(score), 32'd1);
    check_output("pix_note_red", 32'({pix_r, pix_g, pix_b}), 32'(RED));
    apply_stimulus(1'b0, 1'b0, 3'd0, 4'b0000, 11'd180, 11'd60);
    check_output("lane0_empty", 32'({pix_r, pix_g, pix_b}), 32'(WHITE));
    check_output("hit_pulse_end", 32'(hit_ok), 32'd0);
    apply_stimulus(1'b0, 1'b0, 3'd0, 4'b0001, 11'd0, 11'd0);
    check_output("hit_empty", 32'(hit_ok), 32'd0);
    check_output("hit_empty_score", 32'(score), 32'd1);

    $display("[TB] miss at window edge");
    do_reset();
    apply_stimulus(1'b0, 1'b1, 3'd0, '0, 11'd0, 11'd0);
    run_frames(114);
    check_output("no_miss_at_24", 32'(miss), 32'd0);
    run_frames(1);
    check_output("miss_at_20", 32'(miss), 32'd1);
    apply_stimulus(1'b0, 1'b0, 3'd0, '0, 11'd180, 11'd25);
    check_output("miss_popped", 32'({pix_r, pix_g, pix_b}), 32'(WHITE));
    check_output("miss_pulse_end", 32'(miss), 32'd0);

    $display("[TB] full lane");
    do_reset();
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 3'd1, '0, 11'd0, 11'd0);
    probe_ready(3'd1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 3'd1, '0, 11'd0, 11'd0);
    probe_ready(3'd3, 1'b1);
    probe_ready(3'd5, 1'b0);

    $display("[TB] reset with score and queued notes");
    do_reset();
    for (int l = 0; l < 4; l++) apply_stimulus(1'b0, 1'b1, 3'(l), '0, 11'd0, 11'd0);
    run_frames(1);
    for (int l = 0; l < 3; l++) apply_stimulus(1'b0, 1'b1, 3'(l), '0, 11'd0, 11'd0);
    run_frames(108);
    apply_stimulus(1'b0, 1'b0, 3'd0, 4'b1111, 11'd0, 11'd0);
    check_output("score_4", 32'(score), 32'd4);
    apply_stimulus(1'b0, 1'b0, 3'd0, 4'b0111, 11'd0, 11'd0);
    check_output("score_7", 32'(score), 32'd7);
    apply_stimulus(1'b0, 1'b1, 3'd1, '0, 11'd0, 11'd0);
    apply_stimulus(1'b0, 1'b1, 3'd1, '0, 11'd0, 11'd0);
    #2;
    do_reset();
    apply_stimulus(1'b0, 1'b0, 3'd1, '0, 11'd240, 11'd500);
    check_output("queues_cleared", 32'({pix_r, pix_g, pix_b}), 32'(WHITE));
    apply_stimulus(1'b0, 1'b1, 3'd0, '0, 11'd0, 11'd0);
    run_frames(95);
    apply_stimulus(1'b0, 1'b0, 3'd0, 4'b0001, 11'd0, 11'd0);
    check_output("hit_early", 32'(hit_ok), 32'd0);
    check_output("hit_early_score", 32'(score), 32'd0);

    $display("[TB] random traffic");
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int l = 0; l < LANES; l++) rand_hit[l] = (($urandom % 8) == 0);
      apply_stimulus((($urandom % 3) == 0), (($urandom % 4) == 0), 3'($urandom % 8),
                     rand_hit, 11'($urandom_range(100, 520)), 11'($urandom_range(0, 560)));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/arrow_lane_renderer.md
# arrow_lane_renderer

Parametrised note-highway renderer for the dance game display. It generalises the fixed four-arrow target row to LANES lanes. Each lane has a small queue of scrolling notes that rise from SPAWN_Y toward the target row once per frame, and player hit pulses are judged against a timing window. The block sits between the game sequencer (spawn/hit sources) and the VGA controller (pixel coordinates in, RGB out).

## Interface
- LANES, 4, number of lanes (1–8)
- NOTES, 4, queue depth per lane (power of 2, 2–8)
- ARROW_SIZE, 72, side of target frame and note box, pixels
- LANE_X0, 146, x of lane 0 left edge
- LANE_PITCH, 92, x spacing between lanes
- TARGET_Y, 36, y of target row top edge
- SPAWN_Y, 480, y assigned to newly spawned notes
- SPEED, 4, pixels scrolled per frame
- WINDOW, 12, hit tolerance, pixels; constraint TARGET_Y >= WINDOW + SPEED
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- pix_x  in  11  current pixel x from VGA controller
- pix_y  in  11  current pixel y from VGA controller
- frame_start  in  1  one-cycle pulse, once per frame, during vblank
- spawn_valid  in  1  request to add a note
- spawn_lane  in  3  target lane of spawn (values >= LANES ignored)
- spawn_ready  out  1  combinational: lane spawn_lane not full and in range
- hit  in  LANES  per-lane one-cycle press pulses
- hit_ok  out  LANES  registered one-cycle pulse: judged hit
- miss  out  LANES  registered one-cycle pulse: note expired
- score  out  16  count of hits, saturating
- pix_r, pix_g, pix_b  out  10 each  registered pixel colour

## Operation
- Per lane: ring buffer of NOTES 11-bit y values, head/tail pointers, count 0..NOTES. Head is always the oldest (topmost) note because all notes spawn at SPAWN_Y and scroll equally.
- Spawn: accepted when spawn_valid && spawn_ready. The entry is written at tail with y=SPAWN_Y and count increments. Otherwise the request is dropped; there is no stall.
- Scroll: on frame_start, every occupied entry gets y -= SPEED. Arithmetic is 11-bit unsigned; the constraint guarantees no underflow before expiry.
- Miss: on frame_start, if the post-scroll head y < TARGET_Y − WINDOW, pop the head and pulse miss[l] next cycle. At most one miss per lane per frame.
- Hit: on hit[l], if count>0 and |head_y − TARGET_Y| <= WINDOW, pop the head, pulse hit_ok[l] next cycle, and increment score (hold at 0xFFFF). A hit on an empty lane or outside the window does nothing.
- Simultaneous events, same lane, same cycle:
  - Hit with frame_start: the hit is judged on the pre-scroll y. If popped, the miss check applies to the new head's post-scroll y.
  - Spawn with pop: both happen, and count is unchanged. spawn_ready is computed from the pre-pop count, so a full lane refuses the spawn even on a pop cycle.
  - Spawn with frame_start: the new entry holds SPAWN_Y unscrolled.
- Lane l left edge: X_l = LANE_X0 + l·LANE_PITCH.
- Render priority, highest first:
  - Note: pixel in [X_l, X_l+ARROW_SIZE) × [y, y+ARROW_SIZE) for any occupied entry. Colour by l mod 4: 0 red (3FF,000,000), 1 blue (000,000,3FF), 2 green (000,3FF,000), 3 yellow (3FF,3FF,000).
  - Target frame: 4-px outline of [X_l, X_l+ARROW_SIZE) × [TARGET_Y, TARGET_Y+ARROW_SIZE), colour 2A8 on all channels.
  - Background: 3FF on all channels.

## Timing
- Reset values: pix_r/g/b = 0, hit_ok = 0, miss = 0, score = 0, all queues empty. spawn_ready therefore follows lane validity only.
- Pixel latency: one cycle from pix_x/pix_y to pix_r/g/b.
- Queue state, score, hit_ok and miss update on the clk edge following the triggering input.
- Reset mid-frame clears everything immediately (asynchronous). Pixels resume on the first clk after release.

## Test plan
- Reset, then pixels (0,0), (146,36), (186,76) → one cycle later 3FF/3FF/3FF, 2A8 gray, 3FF white (frame interior).
- Spawn lane 2, four frame_starts → note y=464. Pixel (330,470) → (000,3FF,000). Pixel (330,463) → background.
- Spawn lane 0, 108 frame_starts (y=48), pulse hit[0] → hit_ok[0] for one cycle, score=1, lane 0 empty. An extra hit[0] → no pulse, score stays 1.
- Spawn lane 0, 114 frames (y=24, still in window, no miss). Frame 115 (y=20) → miss[0] pulse, lane empty.
- Spawn four notes on lane 1 → spawn_ready low for lane 1 and the fifth spawn is dropped; spawn_lane=3 still shows ready; spawn_lane=5 shows not ready.
- Assert rst with notes queued and score=7 → all outputs 0, queues empty. Hit pulse outside the window (y=100) after re-spawn → no effect.
